// File: rtl/cu_wg_dispatcher_pkg.sv
// Package e_gpu_dispatch_pkg: shared types and constants for the work-group
// dispatcher. NUM_COMPUTE_UNITS can be set from the build command line. It
// defaults to 4 when the build does not define it.
//   dispatch_state_t : dispatcher FSM states
//   WG_ID_W_DEFAULT  : default width of WG count / WG id
//   NUM_CU_DEFAULT   : default number of compute units
//   ptr_width()      : index width for an N-entry vector (minimum 1 bit)
`ifndef NUM_COMPUTE_UNITS
`define NUM_COMPUTE_UNITS 4
`endif

package e_gpu_dispatch_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPATCH = 2'd1,
        DRAIN    = 2'd2,
        DONE     = 2'd3
    } dispatch_state_t;

    localparam int WG_ID_W_DEFAULT = 16;
    localparam int NUM_CU_DEFAULT  = `NUM_COMPUTE_UNITS;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cu_wg_dispatcher_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
// The search starts at ptr and moves upward, wrapping at N. The first
// requester found wins.
//   req     in  N      request vector
//   ptr     in  PTR_W  highest-priority index
//   gnt     out N      one-hot grant
//   gnt_idx out PTR_W  index of the granted requester
//   any_gnt out 1      some requester was granted
module rr_arbiter
    import e_gpu_dispatch_pkg::*;
#(
    parameter int N     = 4,
    parameter int PTR_W = ptr_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [PTR_W-1:0] gnt_idx,
    output logic             any_gnt
);

    logic [PTR_W-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any_gnt = 1'b0;
        idx     = '0;
        for (int i = 0; i < N; i++) begin
            idx = PTR_W'((int'(ptr) + i) % N);
            if (!any_gnt && req[idx]) begin
                any_gnt  = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/cu_wg_dispatcher.sv
// cu_wg_dispatcher: distributes a kernel's work-groups round-robin over the
// compute units. At most one WG is in flight per CU, and each CU has its own
// valid/ready handshake. When every WG has been handed out and has finished,
// each CU gets one sleep request pulse, then done_o pulses.
// Optional build macro DISPATCH_PERF_CNT_EN adds the perf_cycles_o and
// perf_stall_o counters.
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   start_i         kernel launch pulse (sampled in IDLE only)
//   num_wg_i        WG count, sampled together with start_i
//   cu_active_i     per-CU "powered and clocked" status
//   wg_valid_o      one-hot WG offer
//   wg_id_o         id of the offered WG
//   wg_ready_i      per-CU accept
//   wg_done_i       per-CU completion pulse
//   cu_sleep_req_o  per-CU "no further work" pulse
//   busy_o, done_o  kernel in progress / kernel complete pulse
//
// state    | meaning
// IDLE     | waiting for start_i
// DISPATCH | offering WGs to eligible CUs
// DRAIN    | all WGs handed out, waiting for completions and sleep requests
// DONE     | one-cycle completion pulse
module cu_wg_dispatcher
    import e_gpu_dispatch_pkg::*;
#(
    parameter int NUM_CU  = NUM_CU_DEFAULT,
    parameter int WG_ID_W = WG_ID_W_DEFAULT
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic [WG_ID_W-1:0] num_wg_i,
    input  logic [NUM_CU-1:0]  cu_active_i,
    output logic [NUM_CU-1:0]  wg_valid_o,
    output logic [WG_ID_W-1:0] wg_id_o,
    input  logic [NUM_CU-1:0]  wg_ready_i,
    input  logic [NUM_CU-1:0]  wg_done_i,
    output logic [NUM_CU-1:0]  cu_sleep_req_o,
    output logic               busy_o,
    output logic               done_o
`ifdef DISPATCH_PERF_CNT_EN
    ,
    output logic [31:0]        perf_cycles_o,
    output logic [31:0]        perf_stall_o
`endif
);

    localparam int PTR_W = ptr_width(NUM_CU);

    dispatch_state_t    state_q, state_d;
    logic [WG_ID_W-1:0] remaining_q, next_id_q;
    logic [PTR_W-1:0]   rr_ptr_q, offer_idx_q;
    logic [NUM_CU-1:0]  busy_q, slept_q;

    logic [NUM_CU-1:0]  gnt;
    logic [PTR_W-1:0]   gnt_idx;
    logic               any_gnt;
    logic               offer_pending, handshake, grant, launch;

    assign offer_pending = |wg_valid_o;
    assign handshake     = |(wg_valid_o & wg_ready_i);
    assign launch        = (state_q == IDLE) && start_i;
    // busy_q is used before the clear from wg_done_i. A CU that finishes in
    // this cycle can only be chosen at the next arbitration.
    assign grant         = (state_q == DISPATCH) && !offer_pending && any_gnt;

    rr_arbiter #(.N(NUM_CU), .PTR_W(PTR_W)) u_arb (
        .req     (cu_active_i & ~busy_q),
        .ptr     (rr_ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any_gnt (any_gnt)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (start_i) state_d = (num_wg_i != '0) ? DISPATCH : DRAIN;
            DISPATCH: if (handshake && remaining_q == WG_ID_W'(1)) state_d = DRAIN;
            // Every idle CU that has not slept yet pulses in this cycle, so
            // with busy clear all CUs will have slept by the next edge.
            DRAIN:    if (busy_q == '0 && (slept_q | cu_sleep_req_o) == '1) state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o         = (state_q != IDLE);
        done_o         = (state_q == DONE);
        cu_sleep_req_o = '0;
        if (state_q == DRAIN) cu_sleep_req_o = ~busy_q & ~slept_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            remaining_q <= '0;
            next_id_q   <= '0;
            rr_ptr_q    <= '0;
            offer_idx_q <= '0;
            busy_q      <= '0;
            slept_q     <= '0;
            wg_valid_o  <= '0;
            wg_id_o     <= '0;
        end else if (launch) begin
            remaining_q <= num_wg_i;
            next_id_q   <= '0;
            busy_q      <= '0;
            slept_q     <= '0;
        end else begin
            busy_q  <= (busy_q & ~wg_done_i) | (handshake ? wg_valid_o : '0);
            slept_q <= slept_q | cu_sleep_req_o;
            if (handshake) begin
                next_id_q   <= next_id_q + 1'b1;
                remaining_q <= remaining_q - 1'b1;
                rr_ptr_q    <= (offer_idx_q == PTR_W'(NUM_CU - 1)) ? '0 : offer_idx_q + 1'b1;
                wg_valid_o  <= '0;
            end else if (grant) begin
                wg_valid_o  <= gnt;
                wg_id_o     <= next_id_q;
                offer_idx_q <= gnt_idx;
            end
        end
    end

`ifdef DISPATCH_PERF_CNT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_cycles_o <= '0;
            perf_stall_o  <= '0;
        end else if (launch) begin
            perf_cycles_o <= '0;
            perf_stall_o  <= '0;
        end else begin
            if (busy_o && perf_cycles_o != '1) perf_cycles_o <= perf_cycles_o + 1'b1;
            if (offer_pending && !handshake && perf_stall_o != '1) perf_stall_o <= perf_stall_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_cu_wg_dispatcher.sv
// Testbench for cu_wg_dispatcher with 4 compute units. The reference model
// tracks which CUs hold work, the round-robin pointer and the kernel progress.
// Every cycle it predicts the exact offer, sleep and done outputs.
module tb_cu_wg_dispatcher;

    localparam int N      = 4;
    localparam int W      = 16;
    localparam int BUDGET = 600;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic         start_i = 1'b0;
    logic [W-1:0] num_wg_i = '0;
    logic [N-1:0] cu_active_i = '0;
    logic [N-1:0] wg_valid_o;
    logic [W-1:0] wg_id_o;
    logic [N-1:0] wg_ready_i = '0;
    logic [N-1:0] wg_done_i = '0;
    logic [N-1:0] cu_sleep_req_o;
    logic         busy_o;
    logic         done_o;
`ifdef DISPATCH_PERF_CNT_EN
    logic [31:0]  perf_cycles_o;
    logic [31:0]  perf_stall_o;
`endif

    always #5 clk_i = ~clk_i;

    cu_wg_dispatcher #(.NUM_CU(N), .WG_ID_W(W)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .start_i        (start_i),
        .num_wg_i       (num_wg_i),
        .cu_active_i    (cu_active_i),
        .wg_valid_o     (wg_valid_o),
        .wg_id_o        (wg_id_o),
        .wg_ready_i     (wg_ready_i),
        .wg_done_i      (wg_done_i),
        .cu_sleep_req_o (cu_sleep_req_o),
        .busy_o         (busy_o),
        .done_o         (done_o)
`ifdef DISPATCH_PERF_CNT_EN
        ,
        .perf_cycles_o  (perf_cycles_o),
        .perf_stall_o   (perf_stall_o)
`endif
    );

    int checks = 0;
    int errors = 0;
    int m_ptr = 0;
    int got_cu [64];
    int cfg_lat [64];
    int cfg_ready_rand = 0;
    int cfg_hold_cu = -1;
    int cfg_hold_len = 0;
    int valid_cnt_cu [N];
    int last_done_cyc = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic bit_at(input logic [N-1:0] v, input int i);
        logic [N-1:0] t;
        t = v >> i;
        return t[0];
    endfunction

    function automatic logic [N-1:0] onehot(input int i);
        return N'(1) << i;
    endfunction

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 1'b0; start_i = 1'b0; wg_ready_i = '0; wg_done_i = '0;
        #1;
        chk("rst_valid", wg_valid_o, 0);
        chk("rst_id", wg_id_o, 0);
        chk("rst_sleep", cu_sleep_req_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        m_ptr = 0;
    endtask

    // Launches one kernel and steps it cycle by cycle against the model until
    // done_o is seen. Outputs are sampled on the falling edge.
    task automatic run_kernel(input int nwg, input logic [N-1:0] act);
        logic [N-1:0] busy, slept, exp_sleep, exp_valid, rdy, dn;
        int remaining, next_id, pend_cu, pend_id, hold_left, cyc, g;
        bit pend, in_drain, done_now, finished, hs;
        int done_at [N];
        int sleep_cnt [N];
        int done_cnt;

        @(negedge clk_i);
        start_i = 1'b1; num_wg_i = W'(nwg); cu_active_i = act;
        wg_ready_i = '0; wg_done_i = '0;
        @(negedge clk_i);
        start_i = 1'b0; num_wg_i = W'($urandom);

        busy = '0; slept = '0; remaining = nwg; next_id = 0; pend = 0; pend_cu = 0; pend_id = 0;
        in_drain = (nwg == 0); done_now = 0; finished = 0; hold_left = 0; done_cnt = 0;
        for (int i = 0; i < N; i++) begin
            done_at[i] = -1; sleep_cnt[i] = 0; valid_cnt_cu[i] = 0;
        end

        for (cyc = 0; cyc < BUDGET && !finished; cyc++) begin
            exp_valid = pend ? onehot(pend_cu) : '0;
            exp_sleep = in_drain ? (~busy & ~slept) : '0;
            chk("valid", wg_valid_o, exp_valid);
            if (pend) chk("wg_id", wg_id_o, pend_id);
            chk("busy_o", busy_o, 1);
            chk("sleep", cu_sleep_req_o, exp_sleep);
            chk("done_o", done_o, done_now);
            for (int i = 0; i < N; i++) begin
                if (bit_at(wg_valid_o, i)) valid_cnt_cu[i]++;
                if (bit_at(cu_sleep_req_o, i)) sleep_cnt[i]++;
            end
            if (done_o) begin
                done_cnt++;
                last_done_cyc = cyc;
            end
            if (done_now) finished = 1;

            rdy = (cfg_ready_rand != 0) ? N'($urandom) : '1;
            if (pend) begin
                rdy = rdy & ~onehot(pend_cu);
                if (hold_left == 0) rdy = rdy | onehot(pend_cu);
            end
            dn = '0;
            for (int i = 0; i < N; i++) begin
                if (done_at[i] == cyc) dn = dn | onehot(i);
                else if (cfg_ready_rand != 0 && !bit_at(busy, i) && !(pend && pend_cu == i)
                         && $urandom_range(0, 3) == 0)
                    dn = dn | onehot(i);
            end
            wg_ready_i = rdy;
            wg_done_i  = dn;

            if (done_now) begin
                done_now = 0;
            end else if (in_drain) begin
                slept = slept | exp_sleep;
                if (busy == '0) begin
                    in_drain = 0;
                    done_now = 1;
                end
                busy = busy & ~dn;
            end else begin
                hs = pend && bit_at(rdy, pend_cu);
                g = -1;
                if (!pend) begin
                    for (int k = 0; k < N; k++) begin
                        if (g < 0 && bit_at(act & ~busy, (m_ptr + k) % N)) g = (m_ptr + k) % N;
                    end
                end
                busy = busy & ~dn;
                if (hs) begin
                    busy = busy | onehot(pend_cu);
                    got_cu[pend_id] = pend_cu;
                    done_at[pend_cu] = cyc + cfg_lat[pend_id];
                    next_id++;
                    remaining--;
                    m_ptr = (pend_cu + 1) % N;
                    pend = 0;
                    if (remaining == 0) in_drain = 1;
                end else if (g >= 0) begin
                    pend = 1; pend_cu = g; pend_id = next_id;
                    hold_left = (cfg_ready_rand != 0) ? int'($urandom_range(0, 3))
                              : ((g == cfg_hold_cu) ? cfg_hold_len : 0);
                end else if (pend && hold_left > 0) begin
                    hold_left--;
                end
            end
            @(negedge clk_i);
        end

        wg_ready_i = '0;
        wg_done_i  = '0;
        chk("kernel_finished", finished, 1);
        chk("done_count", done_cnt, 1);
        chk("wg_count", next_id, nwg);
        for (int i = 0; i < N; i++) chk("sleep_count", sleep_cnt[i], 1);
        chk("idle_busy", busy_o, 0);
        chk("idle_done", done_o, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int vsum;
        logic [N-1:0] act;

        do_reset();

        // Test 1: all CUs active, ready tied high, completion 3 cycles after accept.
        for (int i = 0; i < 64; i++) cfg_lat[i] = 3;
        run_kernel(6, 4'b1111);
        chk("t1_cu_id0", got_cu[0], 0);
        chk("t1_cu_id1", got_cu[1], 1);
        chk("t1_cu_id2", got_cu[2], 2);
        chk("t1_cu_id3", got_cu[3], 3);
        chk("t1_cu_id4", got_cu[4], 0);
        chk("t1_cu_id5", got_cu[5], 1);

        // Test 2: empty kernel.
        run_kernel(0, 4'b1111);
        vsum = 0;
        for (int i = 0; i < N; i++) vsum += valid_cnt_cu[i];
        chk("t2_no_offer", vsum, 0);
        chk("t2_done_latency", last_done_cyc, 1);

        // Test 3: CU2 withholds ready for 5 cycles.
        for (int i = 0; i < 64; i++) cfg_lat[i] = 30;
        cfg_hold_cu = 2; cfg_hold_len = 5;
        run_kernel(4, 4'b1111);
        chk("t3_offer_len", valid_cnt_cu[2], 6);
        cfg_hold_cu = -1; cfg_hold_len = 0;

        // Test 4: only CU0 and CU2 active.
        for (int i = 0; i < 64; i++) cfg_lat[i] = 3;
        run_kernel(4, 4'b0101);
        for (int i = 0; i < 4; i++) chk("t4_cu_allowed", (got_cu[i] == 0 || got_cu[i] == 2), 1);
        for (int i = 1; i < 4; i++) chk("t4_alternate", (got_cu[i] != got_cu[i-1]), 1);

        // Test 5: CU0 finishes in the same cycle it would otherwise be granted.
        do_reset();
        cfg_lat[0] = 7; cfg_lat[1] = 2; cfg_lat[2] = 20; cfg_lat[3] = 20;
        cfg_lat[4] = 3; cfg_lat[5] = 3;
        run_kernel(6, 4'b1111);
        chk("t5_skip_cu0", got_cu[4], 1);
        chk("t5_cu0_next", got_cu[5], 0);

        // Randomized kernels: random masks, ready stalls, latencies and stray pulses.
        cfg_ready_rand = 1;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 64; i++) cfg_lat[i] = int'($urandom_range(1, 6));
            act = N'($urandom_range(1, 15));
            run_kernel(int'($urandom_range(1, 9)), act);
        end
        cfg_ready_rand = 0;

        // Test 6: reset while an offer is pending.
        @(negedge clk_i);
        start_i = 1'b1; num_wg_i = W'(5); cu_active_i = 4'b1111; wg_ready_i = '0;
        @(negedge clk_i);
        start_i = 1'b0;
        for (int k = 0; k < 10 && wg_valid_o == '0; k++) @(negedge clk_i);
        chk("t6_offer_seen", |wg_valid_o, 1);
        #2 rst_ni = 1'b0;
        #1;
        chk("t6_valid_cleared", wg_valid_o, 0);
        chk("t6_busy_cleared", busy_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        m_ptr = 0;
        for (int i = 0; i < 64; i++) cfg_lat[i] = 2;
        run_kernel(3, 4'b1111);
        chk("t6_cu_id0", got_cu[0], 0);
        chk("t6_cu_id1", got_cu[1], 1);
        chk("t6_cu_id2", got_cu[2], 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
